// File: rtl/lcd_write_engine_if.sv
// Command handshake bundle between the LCD sequencers and the write engine.
// master = sequencer side, slave = lcd_write_engine.
interface lcd_write_engine_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rs;
    logic       cmd_rw;
    logic [7:0] cmd_data;
    logic       cmd_nib;
    logic       cmd_long;

    modport master (
        output cmd_valid, cmd_rs, cmd_rw, cmd_data, cmd_nib, cmd_long,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_rs, cmd_rw, cmd_data, cmd_nib, cmd_long,
        output cmd_ready
    );
endinterface

// File: rtl/lcd_write_engine.sv
// HD44780-style LCD write engine: one byte per handshake, programmable E timing.
// Define LCD_WR_COUNT_EN to add the wr_count output (completed-write counter).
module lcd_write_engine #(
    parameter int BUS_MODE      = 4,
    parameter int SETUP_CYC     = 2,
    parameter int ACTIVE_CYC    = 12,
    parameter int HOLD_CYC      = 1,
    parameter int GAP_CYC       = 50,
    parameter int POST_CYC      = 2000,
    parameter int LONG_POST_CYC = 82000,
    parameter int CNT_W         = 17
) (
    input  logic                clk,
    input  logic                reset,
    lcd_write_engine_if.slave   cmd,
    output logic                lcd_e,
    output logic                lcd_rs,
    output logic                lcd_rw,
    output logic [BUS_MODE-1:0] lcd_db,
    output logic                busy,
`ifdef LCD_WR_COUNT_EN
    output logic [15:0]         wr_count,
`endif
    output logic                done
);

    typedef enum logic [2:0] {
        IDLE, SETUP, ACTIVE, HOLD, GAP, POST
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] post_last;
    logic [7:0]       data_q;
    logic             rs_q;
    logic             rw_q;
    logic             nib_q;
    logic             long_q;
    logic             second;
    logic             ready_q;

    assign cmd.cmd_ready = ready_q;
    assign post_last = long_q ? CNT_W'(LONG_POST_CYC - 1)
                              : CNT_W'(POST_CYC - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            nib_q   <= 1'b0;
            long_q  <= 1'b0;
            second  <= 1'b0;
            ready_q <= 1'b0;
            lcd_e   <= 1'b0;
            lcd_rs  <= 1'b0;
            lcd_rw  <= 1'b0;
            lcd_db  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            cnt  <= cnt + 1'b1;
            unique case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    cnt     <= '0;
                    if (cmd.cmd_valid && ready_q) begin
                        state   <= SETUP;
                        ready_q <= 1'b0;
                        busy    <= 1'b1;
                        data_q  <= cmd.cmd_data;
                        rs_q    <= cmd.cmd_rs;
                        rw_q    <= cmd.cmd_rw;
                        nib_q   <= cmd.cmd_nib;
                        long_q  <= cmd.cmd_long;
                        second  <= 1'b0;
                        lcd_rs  <= cmd.cmd_rs;
                        lcd_rw  <= cmd.cmd_rw;
                        // 4-bit mode truncates to the upper nibble
                        lcd_db  <= BUS_MODE == 8
                                 ? BUS_MODE'(cmd.cmd_data)
                                 : BUS_MODE'({4'b0, cmd.cmd_data[7:4]});
                    end
                end
                SETUP: begin
                    if (cnt == CNT_W'(SETUP_CYC - 1)) begin
                        state <= ACTIVE;
                        cnt   <= '0;
                        lcd_e <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (cnt == CNT_W'(ACTIVE_CYC - 1)) begin
                        state <= HOLD;
                        cnt   <= '0;
                        lcd_e <= 1'b0;
                    end
                end
                HOLD: begin
                    if (cnt == CNT_W'(HOLD_CYC - 1)) begin
                        cnt    <= '0;
                        lcd_rs <= 1'b0;
                        lcd_rw <= 1'b0;
                        if (BUS_MODE == 4 && !second && !nib_q) begin
                            state <= GAP;
                        end else begin
                            state <= POST;
                            done  <= (post_last == '0);
                        end
                    end
                end
                GAP: begin
                    if (cnt == CNT_W'(GAP_CYC - 1)) begin
                        state  <= SETUP;
                        cnt    <= '0;
                        second <= 1'b1;
                        lcd_rs <= rs_q;
                        lcd_rw <= rw_q;
                        lcd_db <= BUS_MODE'({4'b0, data_q[3:0]});
                    end
                end
                POST: begin
                    if (cnt == post_last) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        busy    <= 1'b0;
                        ready_q <= 1'b1;
                        lcd_db  <= '0;
                    end else if (cnt + 1'b1 == post_last) begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef LCD_WR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count <= '0;
        end else if (done) begin
            wr_count <= wr_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lcd_write_engine.sv
// Directed bench for lcd_write_engine: 4-bit and 8-bit instances, short timing.
// Expected cycle numbers are hand-computed from S=2 A=3 H=1 G=4 P=5 LP=9.
module tb_lcd_write_engine;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    lcd_write_engine_if b4 ();
    lcd_write_engine_if b8 ();

    logic       e4, rs4, rw4, busy4, done4;
    logic [3:0] db4;
    logic       e8, rs8, rw8, busy8, done8;
    logic [7:0] db8;
`ifdef LCD_WR_COUNT_EN
    logic [15:0] wc4, wc8;
`endif

    lcd_write_engine #(
        .BUS_MODE(4), .SETUP_CYC(2), .ACTIVE_CYC(3), .HOLD_CYC(1),
        .GAP_CYC(4), .POST_CYC(5), .LONG_POST_CYC(9), .CNT_W(17)
    ) u4 (
        .clk(clk), .reset(reset), .cmd(b4.slave),
        .lcd_e(e4), .lcd_rs(rs4), .lcd_rw(rw4), .lcd_db(db4),
        .busy(busy4),
`ifdef LCD_WR_COUNT_EN
        .wr_count(wc4),
`endif
        .done(done4)
    );

    lcd_write_engine #(
        .BUS_MODE(8), .SETUP_CYC(2), .ACTIVE_CYC(3), .HOLD_CYC(1),
        .GAP_CYC(4), .POST_CYC(5), .LONG_POST_CYC(9), .CNT_W(17)
    ) u8 (
        .clk(clk), .reset(reset), .cmd(b8.slave),
        .lcd_e(e8), .lcd_rs(rs8), .lcd_rw(rw8), .lcd_db(db8),
        .busy(busy8),
`ifdef LCD_WR_COUNT_EN
        .wr_count(wc8),
`endif
        .done(done8)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic       tr_e [0:63];
    logic       tr_rs[0:63];
    logic       tr_busy[0:63];
    logic [7:0] tr_db[0:63];
    logic       aft_ready, aft_busy;
    logic [7:0] aft_db;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop();
        b4.cmd_valid = 1'b0;
        b8.cmd_valid = 1'b0;
    endtask

    task automatic drive(input bit w8, input logic [7:0] d, input bit rs,
                         input bit nib, input bit lng);
        if (w8) begin
            b8.cmd_valid = 1'b1; b8.cmd_data = d; b8.cmd_rs = rs;
            b8.cmd_nib = nib;    b8.cmd_long = lng;
        end else begin
            b4.cmd_valid = 1'b1; b4.cmd_data = d; b4.cmd_rs = rs;
            b4.cmd_nib = nib;    b4.cmd_long = lng;
        end
    endtask

    // Cycle 1 is the first cycle after the accepting edge.
    task automatic run(input bit w8, input logic [7:0] d, input bit rs,
                       input bit nib, input bit lng, input bit hold,
                       output int dcyc);
        logic dn;
        dcyc = 0;
        for (int i = 0; i < 64; i++) begin
            tr_e[i] = 1'b0; tr_rs[i] = 1'b0;
            tr_busy[i] = 1'b0; tr_db[i] = 8'h0;
        end
        drive(w8, d, rs, nib, lng);
        step();
        if (!hold) drop();
        for (int c = 1; c < 64; c++) begin
            tr_e[c]    = w8 ? e8 : e4;
            tr_rs[c]   = w8 ? rs8 : rs4;
            tr_busy[c] = w8 ? busy8 : busy4;
            tr_db[c]   = w8 ? db8 : {4'h0, db4};
            dn         = w8 ? done8 : done4;
            if (dn) begin
                dcyc = c;
                break;
            end
            step();
        end
        drop();
        step();
        aft_ready = w8 ? b8.cmd_ready : b4.cmd_ready;
        aft_busy  = w8 ? busy8 : busy4;
        aft_db    = w8 ? db8 : {4'h0, db4};
    endtask

    function automatic int e_count(input int n);
        int k = 0;
        for (int i = 1; i <= n; i++) if (tr_e[i]) k++;
        return k;
    endfunction

    function automatic int busy_gaps(input int n);
        int k = 0;
        for (int i = 1; i <= n; i++) if (!tr_busy[i]) k++;
        return k;
    endfunction

    int dc;

    initial begin
        b4.cmd_valid = 0; b4.cmd_rs = 0; b4.cmd_rw = 0;
        b4.cmd_data = 0;  b4.cmd_nib = 0; b4.cmd_long = 0;
        b8.cmd_valid = 0; b8.cmd_rs = 0; b8.cmd_rw = 0;
        b8.cmd_data = 0;  b8.cmd_nib = 0; b8.cmd_long = 0;

        step();
        step();
        chk("rst_ready", b4.cmd_ready, 0);
        chk("rst_e", e4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_db", db4, 0);
        chk("rst_done", done4, 0);
        reset = 1'b0;
        step();
        chk("ready_after_rst", b4.cmd_ready, 1);
        chk("ready8_after_rst", b8.cmd_ready, 1);

        // 4-bit full byte 0x28
        run(0, 8'h28, 0, 0, 0, 0, dc);
        chk("t1_done_cyc", dc, 21);
        chk("t1_db_c1", tr_db[1], 8'h2);
        chk("t1_db_gap", tr_db[8], 8'h2);
        chk("t1_db_c11", tr_db[11], 8'h8);
        chk("t1_e_c2", tr_e[2], 0);
        chk("t1_e_c3", tr_e[3], 1);
        chk("t1_e_c5", tr_e[5], 1);
        chk("t1_e_c6", tr_e[6], 0);
        chk("t1_e_c13", tr_e[13], 1);
        chk("t1_e_cnt", e_count(dc), 6);
        chk("t1_ready_after", aft_ready, 1);
        chk("t1_busy_after", aft_busy, 0);
        chk("t1_db_idle", aft_db, 0);

        // 4-bit single nibble
        run(0, 8'h30, 0, 1, 0, 0, dc);
        chk("t2_done_cyc", dc, 11);
        chk("t2_db_c1", tr_db[1], 8'h3);
        chk("t2_db_post", tr_db[7], 8'h3);
        chk("t2_e_cnt", e_count(dc), 3);

        // 8-bit data write
        run(1, 8'h41, 1, 0, 0, 0, dc);
        chk("t3_done_cyc", dc, 11);
        chk("t3_db_c1", tr_db[1], 8'h41);
        chk("t3_db_post", tr_db[8], 8'h41);
        chk("t3_rs_c1", tr_rs[1], 1);
        chk("t3_rs_hold", tr_rs[6], 1);
        chk("t3_rs_post", tr_rs[7], 0);
        chk("t3_e_cnt", e_count(dc), 3);

        // long post with cmd_valid held
        run(0, 8'h01, 0, 0, 1, 1, dc);
        chk("t4_done_cyc", dc, 25);
        chk("t4_busy_gaps", busy_gaps(dc), 0);
        chk("t4_e_cnt", e_count(dc), 6);
        chk("t4_ready_after", aft_ready, 1);
        chk("t4_busy_after", aft_busy, 0);

        // reset during ACTIVE
        drive(0, 8'h28, 1, 0, 0);
        step();
        drop();
        step();
        step();
        step();
        chk("t5_e_active", e4, 1);
        reset = 1'b1;
        step();
        chk("t5_e_rst", e4, 0);
        chk("t5_rs_rst", rs4, 0);
        chk("t5_db_rst", db4, 0);
        chk("t5_busy_rst", busy4, 0);
        chk("t5_done_rst", done4, 0);
        chk("t5_ready_rst", b4.cmd_ready, 0);
        reset = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 25; i++) begin
                step();
                if (done4) seen++;
            end
            chk("t5_no_done", seen, 0);
        end
        chk("t5_ready_back", b4.cmd_ready, 1);
        run(0, 8'h30, 0, 1, 0, 0, dc);
        chk("t5_post_rst_cyc", dc, 11);

`ifdef LCD_WR_COUNT_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk("t6_wc0", wc4, 0);
        run(0, 8'h30, 0, 1, 0, 0, dc);
        chk("t6_wc1", wc4, 1);
        run(0, 8'h30, 0, 1, 0, 0, dc);
        chk("t6_wc2", wc4, 2);
        run(0, 8'h30, 0, 1, 0, 0, dc);
        chk("t6_wc3", wc4, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
